// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic DAC output path.
package ultrasonic_pkg;

  localparam int DAC_FRAME_W = 16;
  localparam logic [3:0] DAC_CMD_WR_UPD = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } dac_tx_state_t;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame_word(input logic [11:0] code);
    return {DAC_CMD_WR_UPD, code};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// Half-period tick generator for the DAC SPI clock; counts only while a frame is active
// so every frame starts from a full half-period.
module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic shift_i,
  output logic half_tick_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  assign half_tick_o = en_i && (cnt_q == '0);
  assign rise_tick_o = half_tick_o && shift_i && !phase_q;
  assign fall_tick_o = half_tick_o && shift_i && phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= RELOAD;
      phase_q <= 1'b0;
    end else begin
      if (!en_i || half_tick_o) cnt_q <= RELOAD;
      else                      cnt_q <= cnt_q - 1'b1;
      // phase 0 = sclk low half, 1 = sclk high half
      if (!shift_i)         phase_q <= 1'b0;
      else if (half_tick_o) phase_q <= ~phase_q;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Ships the DAC code as a 16-bit write-and-update SPI frame (mode 0, MSB first),
// resending on code change or update request and coalescing mid-frame changes.
module dac_spi_tx
  import ultrasonic_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2,
  parameter int CODE_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] dac_code,
  input  logic              update_req,
  output logic              dac_sclk,
  output logic              dac_cs_n,
  output logic              dac_mosi,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frames_sent
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  dac_tx_state_t            state_q;
  logic [CODE_W-1:0]        code_q;
  logic [CODE_W-1:0]        sent_code_q;
  logic                     req_q;
  logic                     primed_q;
  logic [DAC_FRAME_W-2:0]   shreg_q;
  logic [3:0]               bit_cnt_q;
  logic [GW-1:0]            gap_cnt_q;
  logic                     dac_sclk_q;
  logic                     dac_cs_n_q;
  logic                     dac_mosi_q;
  logic                     busy_q;
  logic                     frame_done_q;
  logic [15:0]              frames_sent_q;

  logic                     half_tick;
  logic                     rise_tick;
  logic                     fall_tick;
  logic                     pending_d;
  logic                     launch_d;
  logic [DAC_FRAME_W-1:0]   frame_word_d;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q inside {SETUP, SHIFT, HOLD}),
    .shift_i     (state_q == SHIFT),
    .half_tick_o (half_tick),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  // A change that reverts to the sent code clears itself; only requests are sticky.
  assign pending_d    = req_q || (code_q != sent_code_q);
  // primed_q holds off the first launch until code_q has sampled a real input.
  assign launch_d     = primed_q && pending_d &&
                        ((state_q == IDLE) || ((state_q == GAP) && (gap_cnt_q == '0)));
  assign frame_word_d = dac_frame_word(code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      code_q        <= '0;
      sent_code_q   <= '0;
      req_q         <= 1'b1;
      primed_q      <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      dac_sclk_q    <= 1'b0;
      dac_cs_n_q    <= 1'b1;
      dac_mosi_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      code_q       <= dac_code;
      primed_q     <= 1'b1;
      frame_done_q <= 1'b0;
      if (update_req) req_q <= 1'b1;

      case (state_q)
        IDLE: ;
        SETUP: begin
          if (half_tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (rise_tick) dac_sclk_q <= 1'b1;
          if (fall_tick) begin
            dac_sclk_q <= 1'b0;
            if (bit_cnt_q == '0) begin
              state_q <= HOLD;
            end else begin
              bit_cnt_q  <= bit_cnt_q - 1'b1;
              dac_mosi_q <= shreg_q[DAC_FRAME_W-2];
              shreg_q    <= {shreg_q[DAC_FRAME_W-3:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (half_tick) begin
            state_q       <= GAP;
            dac_cs_n_q    <= 1'b1;
            dac_mosi_q    <= 1'b0;
            frame_done_q  <= 1'b1;
            frames_sent_q <= frames_sent_q + 16'd1;
            gap_cnt_q     <= GW'(CS_GAP - 1);
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Launch overrides the GAP exit so back-to-back frames keep busy high,
      // and clears req_q even if update_req arrives on this same edge.
      if (launch_d) begin
        state_q     <= SETUP;
        req_q       <= 1'b0;
        sent_code_q <= code_q;
        shreg_q     <= frame_word_d[DAC_FRAME_W-2:0];
        dac_mosi_q  <= frame_word_d[DAC_FRAME_W-1];
        bit_cnt_q   <= 4'd15;
        dac_cs_n_q  <= 1'b0;
        busy_q      <= 1'b1;
      end
    end
  end

  assign dac_sclk    = dac_sclk_q;
  assign dac_cs_n    = dac_cs_n_q;
  assign dac_mosi    = dac_mosi_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a pin-level frame monitor pops expected words
// from a scoreboard queue filled by the stimulus sequence.
module tb_dac_spi_tx;

  localparam int CLK_DIV   = 4;
  localparam int CS_GAP    = 2;
  localparam int FRAME_CYC = 34 * CLK_DIV;
  localparam int BUSY_CYC  = FRAME_CYC + CS_GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update_req = 1'b0;
  logic [11:0] dac_code = 12'h000;
  logic        dac_sclk;
  logic        dac_cs_n;
  logic        dac_mosi;
  logic        busy;
  logic        frame_done;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        in_frame = 1'b0;
  int          cur_bits = 0;
  int          last_gap = 0;
  int          last_busy_len = 0;
  int          cs_falls = 0;
  int          frames_seen = 0;
  int          done_cnt = 0;

  dac_spi_tx #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP),
    .CODE_W  (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dac_code    (dac_code),
    .update_req  (update_req),
    .dac_sclk    (dac_sclk),
    .dac_cs_n    (dac_cs_n),
    .dac_mosi    (dac_mosi),
    .busy        (busy),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic        p_sclk = 1'b0;
    logic        p_cs   = 1'b1;
    logic        p_mosi = 1'b0;
    logic [15:0] w = '0;
    int          cs_len = 0;
    int          c_high = 0;
    int          b_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        cur_bits = 0;
        p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0;
        b_run = 0; c_high = 0;
        continue;
      end
      if (busy) b_run++;
      else if (b_run != 0) begin last_busy_len = b_run; b_run = 0; end
      if (frame_done) done_cnt++;
      if (p_cs && !dac_cs_n) begin
        in_frame = 1'b1; w = '0; cur_bits = 0; cs_len = 0;
        last_gap = c_high; cs_falls++;
      end
      if (!dac_cs_n) cs_len++;
      else c_high = p_cs ? c_high + 1 : 1;
      if (in_frame && !p_sclk && dac_sclk) begin
        chk(32'(dac_mosi), 32'(p_mosi), "mosi_setup");
        w = {w[14:0], dac_mosi};
        cur_bits++;
      end
      if (in_frame && !p_cs && dac_cs_n) begin
        in_frame = 1'b0;
        frames_seen++;
        chk(32'(cur_bits), 16, "sclk_rises");
        chk(32'(cs_len), FRAME_CYC, "cs_low_len");
        chk(32'(frame_done), 1, "frame_done_at_cs_rise");
        chk(32'(exp_q.size() > 0), 1, "frame_expected");
        if (exp_q.size() > 0) chk(32'(w), 32'(exp_q.pop_front()), "mosi_word");
        cur_bits = 0;
      end
      p_sclk = dac_sclk; p_cs = dac_cs_n; p_mosi = dac_mosi;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (4) @(negedge clk);
    while (busy !== 1'b0 && n < 4 * BUSY_CYC) begin
      @(negedge clk);
      n++;
    end
    chk(32'(busy), 0, tag);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_update();
    @(negedge clk);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  initial begin
    int n;
    int falls0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk(32'(dac_sclk), 0, "rst_sclk");
    chk(32'(dac_cs_n), 1, "rst_cs_n");
    chk(32'(dac_mosi), 0, "rst_mosi");
    chk(32'(busy), 0, "rst_busy");
    chk(32'(frame_done), 0, "rst_frame_done");
    chk(32'(frames_sent), 0, "rst_frames_sent");

    // Reset release sends the current code once
    exp_q.push_back(16'h3000);
    rst_n = 1'b1;
    wait_idle("idle_after_reset_frame");
    chk(32'(frames_sent), 1, "frames_after_first");
    chk(32'(last_busy_len), BUSY_CYC, "busy_len_first");
    chk(32'(done_cnt), 1, "done_single_pulse");

    // Code change while idle: cs_n falls on the second edge
    dac_code = 12'hABC;
    exp_q.push_back(16'h3ABC);
    @(negedge clk);
    chk(32'(dac_cs_n), 1, "cs_latency_edge1");
    @(negedge clk);
    chk(32'(dac_cs_n), 0, "cs_latency_edge2");
    chk(32'(dac_mosi), 0, "mosi_bit15_at_start");
    wait_idle("idle_after_abc");
    chk(32'(last_busy_len), BUSY_CYC, "busy_len_abc");
    chk(32'(frames_sent), 2, "frames_after_abc");

    // Several changes inside a frame coalesce into one follow-up
    dac_code = 12'h555;
    exp_q.push_back(16'h3555);
    repeat (20) @(negedge clk);
    dac_code = 12'h111;
    repeat (10) @(negedge clk);
    dac_code = 12'h222;
    repeat (10) @(negedge clk);
    dac_code = 12'h333;
    exp_q.push_back(16'h3333);
    wait_idle("idle_after_coalesce");
    chk(32'(last_gap), CS_GAP, "followup_gap");
    chk(32'(frames_sent), 4, "frames_after_coalesce");

    // A change that reverts before the frame ends sends nothing more
    falls0 = cs_falls;
    dac_code = 12'h444;
    exp_q.push_back(16'h3444);
    repeat (20) @(negedge clk);
    dac_code = 12'h777;
    repeat (10) @(negedge clk);
    dac_code = 12'h444;
    wait_idle("idle_after_revert");
    repeat (20) @(negedge clk);
    chk(32'(cs_falls - falls0), 1, "revert_frame_count");
    chk(32'(frames_sent), 5, "frames_after_revert");

    // Constant code: no traffic; then update_req resends it
    falls0 = cs_falls;
    repeat (1000) @(negedge clk);
    chk(32'(cs_falls - falls0), 0, "quiet_no_frames");
    chk(32'(frames_sent), 5, "quiet_frames_sent");
    exp_q.push_back(16'h3444);
    pulse_update();
    wait_idle("idle_after_update_req");
    chk(32'(frames_sent), 6, "frames_after_update_req");

    // Reset during SCLK period 8 abandons the frame; it is resent afterwards
    dac_code = 12'h9A5;
    exp_q.push_back(16'h39A5);
    n = 0;
    while (!(in_frame && cur_bits >= 8) && n < 2 * BUSY_CYC) begin
      @(negedge clk);
      n++;
    end
    chk(32'(cur_bits >= 8), 1, "reached_period8");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(32'(dac_cs_n), 1, "async_rst_cs_n");
    chk(32'(dac_sclk), 0, "async_rst_sclk");
    chk(32'(dac_mosi), 0, "async_rst_mosi");
    chk(32'(busy), 0, "async_rst_busy");
    chk(32'(frames_sent), 0, "async_rst_frames_sent");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("idle_after_midframe_reset");
    chk(32'(frames_sent), 1, "frames_after_midframe_reset");

    // Counter wrap
    @(negedge clk);
    force dut.frames_sent_q = 16'hFFFF;
    #1 release dut.frames_sent_q;
    @(negedge clk);
    chk(32'(frames_sent), 32'h0000_FFFF, "preset_ffff");
    exp_q.push_back(16'h39A5);
    pulse_update();
    wait_idle("idle_after_wrap");
    chk(32'(frames_sent), 0, "frames_sent_wrap");

    chk(32'(exp_q.size()), 0, "scoreboard_empty");
    chk(32'(done_cnt), 32'(frames_seen), "done_pulses_vs_frames");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
